mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the port arbiter and the shared memory.
// The slave modport is the arbiter's view. The master modport is the requester plus memory view.
interface mem_port_arbiter_if;
    logic        IReq;
    logic [31:0] IAddress;
    logic        IAck;
    logic        DReq;
    logic        DWrite;
    logic [31:0] DAddress;
    logic [31:0] DWriteData;
    logic        DAck;
    logic [31:0] ReadData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemReadData;
    logic        Busy;

    modport slave (
        input  IReq, IAddress, DReq, DWrite, DAddress, DWriteData, MemReadData,
        output IAck, DAck, ReadData, MemAddress, MemWriteData, MemRead, MemWrite, Busy
    );

    modport master (
        output IReq, IAddress, DReq, DWrite, DAddress, DWriteData, MemReadData,
        input  IAck, DAck, ReadData, MemAddress, MemWriteData, MemRead, MemWrite, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) ports onto one single-port memory. Each access takes IDLE -> ACCESS -> RESP, with the strobe 1 cycle and the Ack 2 cycles after the grant edge.
// Requests are held until Ack. The loser waits, and D wins ties until it has taken STARVE_LIMIT grants in a row while I waits.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [2:0] Limit = 3'(STARVE_LIMIT);

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] data;
    } memReq_t;

    logic [1:0]  state;
    logic        ownerD;
    logic [2:0]  starveCnt;
    logic [2:0]  starveNext;
    logic [31:0] readData;
    memReq_t     latched;
    logic        anyReq;
    logic        grantD;

    always_comb begin
        anyReq     = bus.IReq | bus.DReq;
        grantD     = bus.DReq && !(bus.IReq && (starveCnt == Limit));
        starveNext = starveCnt;
        // The counter only survives a D grant taken while I is still waiting.
        if (!bus.IReq || !grantD) begin
            starveNext = 3'd0;
        end else if (starveCnt != Limit) begin
            starveNext = starveCnt + 3'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            ownerD    <= 1'b0;
            starveCnt <= 3'd0;
            readData  <= 32'd0;
            latched   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    starveCnt <= starveNext;
                    if (anyReq) begin
                        ownerD <= grantD;
                        state  <= ACCESS;
                        if (grantD) begin
                            latched.write   <= bus.DWrite;
                            latched.address <= bus.DAddress;
                            latched.data    <= bus.DWriteData;
                        end else begin
                            latched.write   <= 1'b0;
                            latched.address <= bus.IAddress;
                        end
                    end
                end
                ACCESS: begin
                    // A fetch always has write clear, so only stores leave ReadData alone.
                    if (!latched.write) begin
                        readData <= bus.MemReadData;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.MemAddress   = latched.address;
    assign bus.MemWriteData = latched.data;
    assign bus.MemRead      = (state == ACCESS) && !latched.write;
    assign bus.MemWrite     = (state == ACCESS) && latched.write;
    assign bus.IAck         = (state == RESP) && !ownerD;
    assign bus.DAck         = (state == RESP) && ownerD;
    assign bus.ReadData     = readData;
    assign bus.Busy         = (state != IDLE);

endmodule
